// File: rtl/fp_mul_result_stage.sv
// Result stage for the FP multiplier: a 2-entry valid/ready FIFO, sticky IEEE exception flags and a delivery counter.
// Define FP_MUL_TRAP_EN to add trap_mask/trap/trap_ack, which stall a masked-exception head until acknowledged.
module fp_mul_result_stage #(
  parameter int NEXP        = 5,
  parameter int NSIG        = 10,
  parameter int NCNT        = 16,
  // Type/exception vector widths, matching NTYPES/NEXCEPTIONS of ieee-754-flags.vh
  parameter int NTYPES      = 6,
  parameter int NEXCEPTIONS = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NEXP+NSIG:0]     in_p,
  input  logic [NTYPES-1:0]      in_flags,
  input  logic [NEXCEPTIONS-1:0] in_exc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NEXP+NSIG:0]     out_p,
  output logic [NTYPES-1:0]      out_flags,
  output logic [NEXCEPTIONS-1:0] out_exc,
  output logic [NEXCEPTIONS-1:0] status,
  input  logic                   status_clr,
  output logic [NCNT-1:0]        count
`ifdef FP_MUL_TRAP_EN
  ,
  input  logic [NEXCEPTIONS-1:0] trap_mask,
  output logic                   trap,
  input  logic                   trap_ack
`endif
);

  typedef struct packed {
    logic [NEXP+NSIG:0]     p;
    logic [NTYPES-1:0]      flags;
    logic [NEXCEPTIONS-1:0] exc;
  } entry_t;

  entry_t                   mem_q [2];
  logic                     wr_ptr_q, rd_ptr_q;
  logic [1:0]               occ_q, occ_d;
  logic                     in_ready_q;
  logic [NEXCEPTIONS-1:0]   status_q, status_d;
  logic [NCNT-1:0]          count_q, count_d;
  logic                     empty, push, pop, clr_en;
  entry_t                   head;

  assign empty = (occ_q == 2'd0);
  // When empty, the slot behind rd_ptr is the one delivered last, so out_* keep showing it.
  assign head  = mem_q[rd_ptr_q ^ empty];

`ifdef FP_MUL_TRAP_EN
  typedef enum logic [1:0] {RUN, TRAP, RELEASE} state_t;

  state_t state_q;
  logic   trap_q;
  logic   trap_hit;

  // RELEASE lets the acknowledged head out once without re-checking the mask.
  assign trap_hit  = !empty && (|(head.exc & trap_mask));
  assign out_valid = !empty && ((state_q == RELEASE) || (state_q == RUN && !trap_hit));
  assign clr_en    = status_clr && (state_q != TRAP);
  assign trap      = trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      trap_q  <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (trap_hit) begin
          state_q <= TRAP;
          trap_q  <= 1'b1;
        end
        TRAP: if (trap_ack) begin
          state_q <= RELEASE;
          trap_q  <= 1'b0;
        end
        RELEASE: if (out_valid && out_ready) state_q <= RUN;
        default: begin
          state_q <= RUN;
          trap_q  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign out_valid = !empty;
  assign clr_en    = status_clr;
`endif

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 2'd1;
    else if (pop && !push) occ_d = occ_q - 2'd1;

    status_d = status_q;
    if (clr_en) status_d = '0;
    if (pop)    status_d = status_d | head.exc;

    count_d = count_q + {{(NCNT-1){1'b0}}, pop};
  end

  // NOTE: the two storage slots are reset too, because out_* must read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
      status_q   <= '0;
      count_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= '{p: in_p, flags: in_flags, exc: in_exc};
      wr_ptr_q   <= wr_ptr_q ^ push;
      rd_ptr_q   <= rd_ptr_q ^ pop;
      occ_q      <= occ_d;
      in_ready_q <= (occ_d != 2'd2);
      status_q   <= status_d;
      count_q    <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_p     = head.p;
  assign out_flags = head.flags;
  assign out_exc   = head.exc;
  assign status    = status_q;
  assign count     = count_q;

endmodule

// File: tb/tb_fp_mul_result_stage.sv
// Directed bench for fp_mul_result_stage: single transfer, backpressure, sticky flags, streaming, wrap, reset, trap.
module tb_fp_mul_result_stage;

  localparam int W  = 16;
  localparam int NT = 6;
  localparam int NE = 5;

  localparam logic [NE-1:0] EXC_INEXACT   = 5'b00001;
  localparam logic [NE-1:0] EXC_UNDERFLOW = 5'b00010;
  localparam logic [NE-1:0] EXC_OVERFLOW  = 5'b00100;
  localparam logic [NE-1:0] EXC_INVALID   = 5'b10000;
  localparam logic [NT-1:0] TYPE_NORMAL   = 6'b000100;
  localparam logic [NT-1:0] TYPE_QNAN     = 6'b010000;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, status_clr;
  logic [W-1:0]  in_p, out_p;
  logic [NT-1:0] in_flags, out_flags;
  logic [NE-1:0] in_exc, out_exc, status;
  logic [15:0]   count;
`ifdef FP_MUL_TRAP_EN
  logic [NE-1:0] trap_mask;
  logic          trap, trap_ack;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int exp_count;

  always #5 clk = ~clk;

  fp_mul_result_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p       (in_p),
    .in_flags   (in_flags),
    .in_exc     (in_exc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_p      (out_p),
    .out_flags  (out_flags),
    .out_exc    (out_exc),
    .status     (status),
    .status_clr (status_clr),
    .count      (count)
`ifdef FP_MUL_TRAP_EN
    ,
    .trap_mask  (trap_mask),
    .trap       (trap),
    .trap_ack   (trap_ack)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int n);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_exc    = '0;
    for (int i = 0; i < n; i++) begin
      in_p = W'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    exp_count = (exp_count + n) % 65536;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; status_clr = 1'b0;
    in_p = '0; in_flags = '0; in_exc = '0;
`ifdef FP_MUL_TRAP_EN
    trap_mask = '0; trap_ack = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_p",     out_p, 0);
    check("rst_status",    status, 0);
    check("rst_count",     count, 0);

    // Single product, one cycle latency
    in_valid = 1'b1; in_p = 16'h3C00; in_flags = TYPE_NORMAL; in_exc = '0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", out_valid, 1);
    check("single_p",     out_p, 16'h3C00);
    check("single_flags", out_flags, TYPE_NORMAL);
    check("single_cnt0",  count, 0);
    step();
    check("single_cnt1",  count, 1);
    check("single_empty", out_valid, 0);
    check("single_hold",  out_p, 16'h3C00);

    // Backpressure: fill to two, hold a third, then drain in order
    out_ready = 1'b0;
    in_valid = 1'b1; in_p = 16'h4000;
    step();
    check("bp_ready1", in_ready, 1);
    in_p = 16'h4200;
    step();
    check("bp_full",   in_ready, 0);
    check("bp_head0",  out_p, 16'h4000);
    in_p = 16'h4400;
    step(); step();
    check("bp_held",   in_ready, 0);
    check("bp_head1",  out_p, 16'h4000);
    out_ready = 1'b1;
    step();
    check("bp_order1", out_p, 16'h4200);
    check("bp_ready2", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_order2", out_p, 16'h4400);
    check("bp_valid",  out_valid, 1);
    step();
    check("bp_count",  count, 4);
    check("bp_empty",  out_valid, 0);

    // Sticky status accumulation and clear-with-delivery
    in_valid = 1'b1; in_p = 16'h3C01; in_exc = EXC_INEXACT;
    step();
    in_p = 16'h7C00; in_exc = EXC_OVERFLOW;
    step();
    check("sticky_one", status, EXC_INEXACT);
    in_valid = 1'b0;
    step();
    check("sticky_or",  status, EXC_INEXACT | EXC_OVERFLOW);
    out_ready = 1'b0;
    in_valid = 1'b1; in_p = 16'h0001; in_exc = EXC_UNDERFLOW;
    step();
    in_valid = 1'b0;
    check("sticky_hold", status, EXC_INEXACT | EXC_OVERFLOW);
    out_ready = 1'b1; status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    check("sticky_clr", status, EXC_UNDERFLOW);
    check("sticky_cnt", count, 7);
    in_exc = '0;

    // Streaming: one product per cycle for 100 cycles, nothing lost
    exp_count = 7;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_p = 16'h1000 + 16'(i);
      step();
      check("stream_valid", out_valid, 1);
      check("stream_p",     out_p, 16'h1000 + 16'(i));
    end
    in_valid = 1'b0;
    step();
    exp_count = exp_count + 100;
    check("stream_count", count, exp_count);
    check("stream_empty", out_valid, 0);

    // Counter wrap: run up to 16'hFFFF, then one more delivery gives 0
    stream(16'hFFFF - exp_count);
    check("wrap_ffff", count, 16'hFFFF);
    stream(1);
    check("wrap_zero", count, 0);

    // Reset with two entries queued; the accept offered during reset is dropped
    out_ready = 1'b0; in_exc = EXC_INEXACT;
    in_valid = 1'b1; in_p = 16'h5000;
    step();
    in_p = 16'h5100;
    step();
    check("prerst_full", in_ready, 0);
    status_clr = 1'b0;
    rst = 1'b1; in_p = 16'h5200;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check("rst2_valid",  out_valid, 0);
    check("rst2_ready",  in_ready, 1);
    check("rst2_status", status, 0);
    check("rst2_count",  count, 0);
    out_ready = 1'b1;
    step();
    check("rst2_noacc",  out_valid, 0);
    check("rst2_cnt",    count, 0);
    in_exc = '0;

`ifdef FP_MUL_TRAP_EN
    // Trap on INVALID: head held until trap_ack, then delivered exactly once
    trap_mask = EXC_INVALID;
    check("trap_idle", trap, 0);
    in_valid = 1'b1; in_p = 16'h7E00; in_flags = TYPE_QNAN; in_exc = EXC_INVALID;
    step();
    in_valid = 1'b0;
    check("trap_gate",  out_valid, 0);
    step();
    check("trap_set",   trap, 1);
    check("trap_novld", out_valid, 0);
    step();
    check("trap_cnt",   count, 0);
    check("trap_stat",  status, 0);
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check("trap_clr",   trap, 0);
    check("trap_rel",   out_valid, 1);
    check("trap_p",     out_p, 16'h7E00);
    step();
    check("trap_once",  count, 1);
    check("trap_inval", status, EXC_INVALID);
    check("trap_done",  out_valid, 0);
    step();
    check("trap_nodup", count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
